// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator (trap > redirect > stall > RAS pop > PC+4).
// Optional call/return stack is built when PC_GEN_RAS_EN is defined.
module pc_gen #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         resetActiveLow,
  input  logic                         enable,
  input  logic                         trapValid,
  input  logic [XLEN-1:0]              trapVector,
  input  logic                         redirectValid,
  input  logic [XLEN-1:0]              redirectTarget,
  input  logic                         predCall,
  input  logic                         predReturn,
  output logic [XLEN-1:0]              programCounter,
  output logic                         misaligned,
  output logic [$clog2(RAS_DEPTH):0]   rasCount
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [XLEN-1:0] seq_pc, ras_top, target;
  logic pop;
  assign seq_pc = programCounter + XLEN'(4);
  assign target = trapValid ? trapVector : redirectTarget;
`ifdef PC_GEN_RAS_EN
  logic [XLEN-1:0] stack [RAS_DEPTH];
  logic [PW-1:0] ptr, ptr_nx;
  logic push;
  assign pop = enable && predReturn && rasCount != '0;
  assign push = enable && predCall;
  assign ptr_nx = ptr + PW'(1);
  assign ras_top = stack[ptr];
  // ptr addresses the top entry; a push into a full stack lands on the oldest slot
  always_ff @(posedge clock or negedge resetActiveLow)
    if (!resetActiveLow) begin
      ptr <= '0;
      rasCount <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
    end else if (trapValid) begin
      ptr <= '0;
      rasCount <= '0;
    end else if (!redirectValid) begin
      if (push && pop) stack[ptr] <= seq_pc;
      else if (pop) begin
        ptr <= ptr - PW'(1);
        rasCount <= rasCount - 1'b1;
      end else if (push) begin
        ptr <= ptr_nx;
        stack[ptr_nx] <= seq_pc;
        rasCount <= (rasCount == (PW+1)'(RAS_DEPTH)) ? rasCount : rasCount + 1'b1;
      end
    end
`else
  logic unused_pred;
  assign unused_pred = predCall ^ predReturn;
  assign pop = 1'b0;
  assign ras_top = '0;
  assign rasCount = '0;
`endif
  always_ff @(posedge clock or negedge resetActiveLow)
    if (!resetActiveLow) begin
      programCounter <= RESET_VECTOR;
      misaligned <= 1'b0;
    end else if (trapValid || redirectValid) begin
      programCounter <= {target[XLEN-1:2], 2'b00};
      misaligned <= |target[1:0];
    end else if (enable) begin
      programCounter <= pop ? ras_top : seq_pc;
      misaligned <= 1'b0;
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen; RAS expectations depend on PC_GEN_RAS_EN.
module tb_pc_gen;
  localparam logic [31:0] RV = 32'h0000_1000;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  typedef struct {
    logic [31:0] pc;
    logic        mis;
    logic [2:0]  cnt;
  } exp_t;
  logic clock = 1'b0, resetActiveLow = 1'b0, enable = 1'b0;
  logic trapValid = 1'b0, redirectValid = 1'b0, predCall = 1'b0, predReturn = 1'b0;
  logic [31:0] trapVector = '0, redirectTarget = '0, programCounter;
  logic misaligned;
  logic [2:0] rasCount;
  exp_t sb[$];
  int tests = 0, fails = 0;
  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .RAS_DEPTH(4)) dut (
    .clock(clock), .resetActiveLow(resetActiveLow), .enable(enable),
    .trapValid(trapValid), .trapVector(trapVector),
    .redirectValid(redirectValid), .redirectTarget(redirectTarget),
    .predCall(predCall), .predReturn(predReturn),
    .programCounter(programCounter), .misaligned(misaligned), .rasCount(rasCount)
  );
  always #5 clock = ~clock;
  function automatic logic [2:0] c(int n);
    return RAS ? 3'(n) : 3'd0;
  endfunction
  task automatic check(string tag);
    exp_t e;
    e = sb.pop_front();
    tests += 3;
    assert (programCounter === e.pc) else begin
      fails++;
      $error("FAIL %s pc got %h want %h", tag, programCounter, e.pc);
    end
    assert (misaligned === e.mis) else begin
      fails++;
      $error("FAIL %s misaligned got %b want %b", tag, misaligned, e.mis);
    end
    assert (rasCount === e.cnt) else begin
      fails++;
      $error("FAIL %s rasCount got %0d want %0d", tag, rasCount, e.cnt);
    end
  endtask
  task automatic step(string tag, logic en, logic tv, logic [31:0] tvec, logic rv,
                      logic [31:0] rtgt, logic call, logic ret,
                      logic [31:0] pc, logic mis, logic [2:0] cnt);
    enable = en; trapValid = tv; trapVector = tvec; redirectValid = rv;
    redirectTarget = rtgt; predCall = call; predReturn = ret;
    sb.push_back('{pc, mis, cnt});
    @(posedge clock);
    #1;
    check(tag);
  endtask
  task automatic adv(string tag, logic call, logic ret, logic [31:0] pc, logic [2:0] cnt);
    step(tag, 1'b1, 1'b0, '0, 1'b0, '0, call, ret, pc, 1'b0, cnt);
  endtask
  task automatic redir(string tag, logic [31:0] tgt, logic mis, logic [2:0] cnt);
    step(tag, 1'b1, 1'b0, '0, 1'b1, tgt, 1'b0, 1'b0, {tgt[31:2], 2'b00}, mis, cnt);
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1;
    sb.push_back('{RV, 1'b0, 3'd0});
    check("reset");
    resetActiveLow = 1'b1;
    adv("seq1", 0, 0, RV + 4, 0);
    adv("seq2", 0, 0, RV + 8, 0);
    adv("seq3", 0, 0, RV + 12, 0);
    redir("to100", 32'h100, 0, 0);
    step("stall1", 0, 0, '0, 0, '0, 1, 1, 32'h100, 0, 0);
    step("stall2", 0, 0, '0, 0, '0, 0, 0, 32'h100, 0, 0);
    step("redir_stall", 0, 0, '0, 1, 32'h200, 0, 0, 32'h200, 0, 0);
    step("trap_prio", 1, 1, 32'h80, 1, 32'h400, 0, 0, 32'h80, 0, 0);
    redir("redir_mis", 32'h302, 1, 0);
    step("mis_hold", 0, 0, '0, 0, '0, 0, 0, 32'h300, 1, 0);
    adv("mis_clear", 0, 0, 32'h304, 0);
    step("trap_mis", 0, 1, 32'h81, 0, '0, 0, 0, 32'h80, 1, 0);
    adv("trap_mis_clr", 0, 0, 32'h84, 0);
    redir("wrap_set", 32'hFFFF_FFFC, 0, 0);
    adv("wrap", 0, 0, 32'h0, 0);
    redir("r10", 32'h10, 0, 0);
    adv("call10", 1, 0, 32'h14, c(1));
    redir("r40", 32'h40, 0, c(1));
    adv("call40", 1, 0, 32'h44, c(2));
    redir("r90", 32'h90, 0, c(2));
    adv("ret90", 0, 1, RAS ? 32'h44 : 32'h94, c(1));
    redir("r48", 32'h48, 0, c(1));
    adv("ret48", 0, 1, RAS ? 32'h14 : 32'h4C, c(0));
    redir("r18", 32'h18, 0, 0);
    adv("ret_empty", 0, 1, 32'h1C, 0);
    redir("r200", 32'h200, 0, 0);
    adv("call200", 1, 0, 32'h204, c(1));
    redir("r300", 32'h300, 0, c(1));
    adv("callret300", 1, 1, RAS ? 32'h204 : 32'h304, c(1));
    redir("r500", 32'h500, 0, c(1));
    adv("ret_replaced", 0, 1, RAS ? 32'h304 : 32'h504, c(0));
    redir("r600", 32'h600, 0, 0);
    adv("callret_empty", 1, 1, 32'h604, c(1));
    adv("ret604", 0, 1, RAS ? 32'h604 : 32'h608, c(0));
    redir("r700", 32'h700, 0, 0);
    adv("call700", 1, 0, 32'h704, c(1));
    step("trap_flush", 1, 1, 32'h80, 0, '0, 1, 0, 32'h80, 0, 0);
    adv("ret_after_flush", 0, 1, 32'h84, 0);
    redir("r0", 32'h0, 0, 0);
    for (int i = 1; i <= 5; i++) adv("call_fill", 1, 0, 32'(4 * i), c(i > 4 ? 4 : i));
    adv("pop1", 0, 1, RAS ? 32'h14 : 32'h18, c(3));
    adv("pop2", 0, 1, RAS ? 32'h10 : 32'h1C, c(2));
    adv("pop3", 0, 1, RAS ? 32'hC : 32'h20, c(1));
    adv("pop4", 0, 1, RAS ? 32'h8 : 32'h24, c(0));
    adv("pop_empty", 0, 1, RAS ? 32'hC : 32'h28, 0);
    redir("r40b", 32'h40, 0, 0);
    adv("call40b", 1, 0, 32'h44, c(1));
    @(negedge clock);
    resetActiveLow = 1'b0;
    enable = 1'b0; predCall = 1'b0; predReturn = 1'b0;
    #2;
    sb.push_back('{RV, 1'b0, 3'd0});
    check("async_reset");
    @(posedge clock);
    #1;
    resetActiveLow = 1'b1;
    adv("ret_after_reset", 0, 1, RV + 4, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
